// File: rtl/mdmhc_enc_arbiter_if.sv
// Handshake bundle for mdmhc_enc_arbiter.
//   req_valid/req_data/req_ready : per-requester input channels
//   out_valid/out_ready/out_data/out_id : shared encoded-result channel
//   busy, enc_count : status
// Modport slave is the arbiter side, master is the requester/consumer side.
interface mdmhc_enc_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [32*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [67:0]          out_data;
   logic [IDW-1:0]       out_id;
   logic                 busy;
   logic [15:0]          enc_count;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, busy, enc_count
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, busy, enc_count
   );
endinterface

// File: rtl/mdmhc_enc_arbiter.sv
// Round-robin arbiter sharing one MDMHC encoder between NREQ requesters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mdmhc_enc_arbiter_if.slave (request channels, encoded output
//                channel, busy, enc_count)
// Optional feature: define MDMHC_ENC_ARB_CNT_EN to build the 16-bit output
// handshake counter on enc_count; otherwise enc_count is tied to zero.
module mdmhc_enc_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mdmhc_enc_arbiter_if.slave     bus
);

   localparam int unsigned DW = 32;
   localparam int unsigned EW = 68;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [IDW-1:0]    id_reg, id_reg_nxt;
   logic [IDW-1:0]    out_id_q, out_id_nxt;
   logic [DW-1:0]     in_reg, in_reg_nxt;
   logic [EW-1:0]     out_data_q, out_data_nxt;
   logic              out_valid_q, out_valid_nxt;
   logic [NREQ-1:0]   rot_c;
   logic [NREQ-1:0]   req_ready_c;
   logic [IDW-1:0]    winner_c;
   logic              any_c;
   logic              win_c;

   // MDMHC encode: raw word, half-word parity, and nibble-pair sums.
   function automatic logic [EW-1:0] mdmhc_encode(input logic [DW-1:0] d);
      logic [EW-1:0] e;
      e[31:0]  = d;
      e[47:32] = d[15:0] ^ d[31:16];
      e[52:48] = 5'(d[3:0])   + 5'(d[11:8]);
      e[57:53] = 5'(d[7:4])   + 5'(d[15:12]);
      e[62:58] = 5'(d[19:16]) + 5'(d[27:24]);
      e[67:63] = 5'(d[23:20]) + 5'(d[31:28]);
      return e;
   endfunction

   // Rotate requests so bit 0 is rr_ptr, then pick the lowest set bit.
   always_comb begin
      rot_c    = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
      any_c    = 1'b0;
      winner_c = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!any_c && rot_c[i]) begin
            any_c    = 1'b1;
            winner_c = IDW'((int'(rr_ptr) + i) % int'(NREQ));
         end
      end
   end

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         id_reg      <= '0;
         in_reg      <= '0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         id_reg      <= id_reg_nxt;
         in_reg      <= in_reg_nxt;
         out_id_q    <= out_id_nxt;
         out_data_q  <= out_data_nxt;
         out_valid_q <= out_valid_nxt;
      end
   end

   // Next-state, grant and register-next logic.
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      id_reg_nxt    = id_reg;
      in_reg_nxt    = in_reg;
      out_id_nxt    = out_id_q;
      out_data_nxt  = out_data_q;
      out_valid_nxt = out_valid_q;
      win_c         = 1'b0;
      req_ready_c   = '0;

      case (state)
         IDLE: win_c = 1'b1;
         ENC: begin
            out_data_nxt  = mdmhc_encode(in_reg);
            out_id_nxt    = id_reg;
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               win_c         = 1'b1;
               out_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A grant overrides the window's fall-back state; out_valid stays low through ENC.
      if (win_c && any_c) begin
         req_ready_c = NREQ'(1) << winner_c;
         in_reg_nxt  = DW'(bus.req_data >> {winner_c, 5'b0});
         id_reg_nxt  = winner_c;
         rr_ptr_nxt  = (winner_c == IDW'(NREQ - 1)) ? '0 : winner_c + IDW'(1);
         state_nxt   = ENC;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.busy      = (state != IDLE);

`ifdef MDMHC_ENC_ARB_CNT_EN
   logic [15:0] enc_cnt_q;

   // Counts completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         enc_cnt_q <= '0;
      else if (out_valid_q && bus.out_ready)
         enc_cnt_q <= enc_cnt_q + 16'd1;
   end

   assign bus.enc_count = enc_cnt_q;
`else
   assign bus.enc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mdmhc_enc_arbiter.sv
// Directed bench for mdmhc_enc_arbiter: reset values, encoding, round robin,
// backpressure, reset while holding, and the handshake counter.
module tb_mdmhc_enc_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
   localparam logic [67:0] ENC_FFFF = 68'hF7BDE_0000_FFFFFFFF;
   localparam logic [67:0] ENC_0001 = 68'h000010001_00000001;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mdmhc_enc_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   mdmhc_enc_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One isolated transfer from IDLE with out_ready held high.
   task automatic xfer(input int r, input logic [31:0] w, input logic [67:0] exp);
      logic [3:0] one_hot;
      one_hot = 4'(1) << r;
      bus.req_data[32*r +: 32] = w;
      bus.req_valid = one_hot;
      bus.out_ready = 1'b1;
      #1;
      chk("xfer_req_ready", bus.req_ready, one_hot);
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk);
      chk("xfer_enc_valid", bus.out_valid, 0);
      chk("xfer_enc_busy", bus.busy, 1);
      @(negedge clk);
      chk("xfer_valid", bus.out_valid, 1);
      chk("xfer_data", bus.out_data, exp);
      chk("xfer_id", bus.out_id, r);
      @(negedge clk);
      chk("xfer_idle_busy", bus.busy, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_id", bus.out_id, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_enc_count", bus.enc_count, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single words and encodings; rr_ptr ends at 0 after requester 3.
      xfer(2, 32'hFFFF_FFFF, ENC_FFFF);
      xfer(0, 32'h0000_0001, ENC_0001);
      xfer(3, 32'h0000_0000, 68'h0);

      // Round robin with every requester pending.
      for (int i = 0; i < 4; i++) bus.req_data[32*i +: 32] = 32'h1111_1111 * (i + 1);
      bus.req_valid = 4'hF;
      bus.out_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("rr_grant", bus.req_ready, 4'(1) << (k % 4));
         if (k > 0) begin
            chk("rr_valid", bus.out_valid, 1);
            chk("rr_id", bus.out_id, (k - 1) % 4);
         end
         @(negedge clk);
         chk("rr_enc_ready", bus.req_ready, 0);
         chk("rr_enc_valid", bus.out_valid, 0);
         if (k == 7) bus.req_valid = '0;
         @(negedge clk);
      end
      chk("rr_last_valid", bus.out_valid, 1);
      chk("rr_last_id", bus.out_id, 3);
      chk("rr_last_ready", bus.req_ready, 0);
      @(negedge clk);
      chk("rr_idle_busy", bus.busy, 0);

      // Backpressure with requesters 1 and 3 pending.
      bus.out_ready = 1'b0;
      bus.req_data[32*1 +: 32] = 32'h0000_0001;
      bus.req_data[32*3 +: 32] = 32'hFFFF_FFFF;
      bus.req_valid = 4'b1010;
      #1;
      chk("bp_grant1", bus.req_ready, 4'b0010);
      @(posedge clk); #1 bus.req_valid = 4'b1000;
      @(posedge clk);
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_id", bus.out_id, 1);
         chk("bp_data", bus.out_data, ENC_0001);
         chk("bp_ready", bus.req_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_grant3", bus.req_ready, 4'b1000);
      chk("bp_done_id", bus.out_id, 1);
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk);
      chk("bp_enc_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("bp3_valid", bus.out_valid, 1);
      chk("bp3_id", bus.out_id, 3);
      chk("bp3_data", bus.out_data, ENC_FFFF);
      @(negedge clk);
      chk("bp_idle_busy", bus.busy, 0);
`ifdef MDMHC_ENC_ARB_CNT_EN
      chk("enc_count", bus.enc_count, 13);
`else
      chk("enc_count", bus.enc_count, 0);
`endif

      // Reset while holding an unaccepted word; rr_ptr would otherwise be 3.
      bus.out_ready = 1'b0;
      bus.req_data[32*2 +: 32] = 32'hFFFF_FFFF;
      bus.req_valid = 4'b0100;
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_data", bus.out_data, 0);
      chk("mid_rst_id", bus.out_id, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ready", bus.req_ready, 0);
      chk("mid_rst_count", bus.enc_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_valid = 4'hF;
      bus.out_ready = 1'b1;
      #1;
      chk("post_rst_grant", bus.req_ready, 4'b0001);
      @(posedge clk); #1 bus.req_valid = '0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
